// File: rtl/sr_flip_flop.sv
// Bank of WIDTH independent clocked set/reset bits with true and complement outputs.
// Both outputs are registered from one next-state value, so qbar always equals ~q.
module sr_flip_flop #(
  parameter int unsigned      WIDTH         = 32'd1,
  parameter int unsigned      CONFLICT_MODE = 32'd0,
  parameter logic [WIDTH-1:0] RESET_VALUE   = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  // Out-of-range modes fall back to set-dominant.
  localparam int unsigned MODE = (CONFLICT_MODE > 32'd3) ? 32'd0 : CONFLICT_MODE;

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] qbar_r;
  logic [WIDTH-1:0] q_next_s;

  function automatic logic conflict_next(input logic cur);
    case (MODE)
      32'd0:   conflict_next = 1'b1;
      32'd1:   conflict_next = 1'b0;
      32'd2:   conflict_next = cur;
      32'd3:   conflict_next = ~cur;
      default: conflict_next = 1'b1;
    endcase
  endfunction

  // Per-bit next-state from the set/clear request pair.
  always_comb begin
    q_next_s = q_r;
    for (int i = 0; i < int'(WIDTH); i++) begin
      case ({s[i], r[i]})
        2'b10:   q_next_s[i] = 1'b1;
        2'b01:   q_next_s[i] = 1'b0;
        2'b11:   q_next_s[i] = conflict_next(q_r[i]);
        default: q_next_s[i] = q_r[i];
      endcase
    end
  end

  // State and complement registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r    <= RESET_VALUE;
      qbar_r <= ~RESET_VALUE;
    end else begin
      q_r    <= q_next_s;
      qbar_r <= ~q_next_s;
    end
  end

  assign q    = q_r;
  assign qbar = qbar_r;

endmodule

// File: tb/tb_sr_flip_flop.sv
// Directed self-checking bench for sr_flip_flop: one-bit instances in every conflict
// mode (plus an illegal mode) share stimulus; a 4-bit instance checks bit independence.
module tb_sr_flip_flop;

  logic       clk = 1'b0;
  logic       rst;
  logic       s1, r1;
  logic [4:0] q1, qb1;
  logic [3:0] s4, r4, q4, qb4;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  // Instances 0..3 use conflict modes 0..3; instance 4 uses illegal mode 7.
  for (genvar g = 0; g < 5; g++) begin : g_dut
    sr_flip_flop #(
      .WIDTH(1), .CONFLICT_MODE((g == 4) ? 7 : g), .RESET_VALUE(1'b0)
    ) u_dut (
      .clk(clk), .rst(rst), .s(s1), .r(r1), .q(q1[g]), .qbar(qb1[g])
    );
  end

  sr_flip_flop #(.WIDTH(4), .CONFLICT_MODE(0), .RESET_VALUE(4'b1010)) u_dut4 (
    .clk(clk), .rst(rst), .s(s4), .r(r4), .q(q4), .qbar(qb4)
  );

  function automatic int mode_of(input int k);
    return (k == 4) ? 7 : k;
  endfunction

  // Reference behaviour of one bit at a clock edge.
  function automatic logic ref_next(input logic cur, input logic sv, input logic rv, input int mode);
    if (sv && rv) begin
      if (mode == 1) return 1'b0;
      if (mode == 2) return cur;
      if (mode == 3) return ~cur;
      return 1'b1;
    end
    if (sv) return 1'b1;
    if (rv) return 1'b0;
    return cur;
  endfunction

  task automatic test_reset();
    rst = 1'b0; s1 = 1'b1; r1 = 1'b0; s4 = 4'b0000; r4 = 4'b0000;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (q1[k] !== 1'b0 || qb1[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_immediate inst%0d: q=%b qbar=%b, expected q=0 qbar=1", k, q1[k], qb1[k]);
      end
    end
    n_checks++;
    if (q4 !== 4'b1010 || qb4 !== 4'b0101) begin
      n_fail++;
      $display("FAIL reset_value4: q=%b qbar=%b, expected q=1010 qbar=0101", q4, qb4);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
        n_checks++;
        if (q1[k] !== 1'b0 || qb1[k] !== 1'b1) begin
          n_fail++;
          $display("FAIL reset_hold inst%0d cyc%0d: q=%b qbar=%b, expected q=0 qbar=1", k, c, q1[k], qb1[k]);
        end
      end
    end
  endtask

  task automatic test_hold_clear_set();
    logic vs [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic vr [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic eq [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s1 = vs[i]; r1 = vr[i];
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
        n_checks++;
        if (q1[k] !== eq[i] || qb1[k] !== ~eq[i]) begin
          n_fail++;
          $display("FAIL hold_clear_set step%0d inst%0d: q=%b qbar=%b, expected q=%b", i, k, q1[k], qb1[k], eq[i]);
        end
      end
    end
  endtask

  task automatic test_conflict();
    logic e;
    s1 = 1'b1; r1 = 1'b1;
    for (int edge_n = 1; edge_n <= 3; edge_n++) begin
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
        case (mode_of(k))
          1, 2:    e = 1'b0;
          3:       e = (edge_n % 2 == 1) ? 1'b1 : 1'b0;
          default: e = 1'b1;
        endcase
        n_checks++;
        if (q1[k] !== e || qb1[k] !== ~e) begin
          n_fail++;
          $display("FAIL conflict mode%0d edge%0d: q=%b qbar=%b, expected q=%b", mode_of(k), edge_n, q1[k], qb1[k], e);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    s1 = 1'b1; r1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (q1 !== 5'b11111) begin
      n_fail++;
      $display("FAIL async_preset: q=%b, expected 11111", q1);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (q1 !== 5'b00000 || qb1 !== 5'b11111) begin
      n_fail++;
      $display("FAIL async_mid_cycle: q=%b qbar=%b, expected q=00000 qbar=11111", q1, qb1);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (q1 !== 5'b00000) begin
      n_fail++;
      $display("FAIL async_release_no_edge: q=%b, expected 00000", q1);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (q1 !== 5'b11111 || qb1 !== 5'b00000) begin
      n_fail++;
      $display("FAIL async_release_edge: q=%b qbar=%b, expected q=11111 qbar=00000", q1, qb1);
    end
  endtask

  task automatic test_multibit();
    @(negedge clk);
    s1 = 1'b0; r1 = 1'b0;
    n_checks++;
    if (q4 !== 4'b1010) begin
      n_fail++;
      $display("FAIL multibit_start: q=%b, expected 1010", q4);
    end
    s4 = 4'b0101; r4 = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (q4 !== 4'b0111 || qb4 !== 4'b1000) begin
      n_fail++;
      $display("FAIL multibit_update: q=%b qbar=%b, expected q=0111 qbar=1000", q4, qb4);
    end
    s4 = 4'b0000; r4 = 4'b0000;
  endtask

  task automatic test_invariant();
    logic exp [5];
    for (int k = 0; k < 5; k++) exp[k] = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      rst = (c == 0) || ($urandom_range(0, 19) == 0);
      s1 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      s4 = 4'($urandom_range(0, 15));
      r4 = 4'($urandom_range(0, 15));
      for (int k = 0; k < 5; k++)
        exp[k] = rst ? 1'b0 : ref_next(exp[k], s1, r1, mode_of(k));
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (qb1 !== ~q1 || qb4 !== ~q4) begin
        n_fail++;
        $display("FAIL invariant cyc%0d: q1=%b qb1=%b q4=%b qb4=%b, expected complements", c, q1, qb1, q4, qb4);
      end
      for (int k = 0; k < 5; k++) begin
        n_checks++;
        if (q1[k] !== exp[k]) begin
          n_fail++;
          $display("FAIL random_model cyc%0d mode%0d: q=%b, expected %b", c, mode_of(k), q1[k], exp[k]);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hold_clear_set();
    test_conflict();
    test_async_reset();
    test_multibit();
    test_invariant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
